// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request dispatcher.
package irq_pkg;

    localparam int IRQ_N    = 4;
    localparam int IRQ_ID_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_t;

    localparam irq_state_t            STATE_RST = IDLE;
    localparam logic [IRQ_ID_W-1:0]   ID_RST    = '0;

    // One-hot vector selecting the line that an ID refers to.
    function automatic logic [IRQ_N-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        logic [IRQ_N-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational 4-input priority select: bit 3 wins, any flags a non-empty input.
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0]    eligible,
    output logic [IRQ_ID_W-1:0] id,
    output logic                any
);

    // Highest set bit of the eligible vector gives the ID.
    always_comb begin
        id  = '0;
        any = |eligible;
        casez (eligible)
            4'b1???: id = 2'd3;
            4'b01??: id = 2'd2;
            4'b001?: id = 2'd1;
            default: id = 2'd0;
        endcase
    end

endmodule

// File: rtl/irq_request_dispatcher.sv
// Interrupt request front end: synchronisers, pending/lost capture and a
// valid/ready offer FSM. Define IRQ_EDGE_DETECT_EN for rising-edge capture
// with lost tracking; leave it undefined for level capture.
module irq_request_dispatcher
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IRQ_N-1:0]    irq_in,
    input  logic [IRQ_N-1:0]    mask_in,
    input  logic                irq_ready,
    input  logic                lost_clr,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [IRQ_N-1:0]    pending,
    output logic [IRQ_N-1:0]    lost
);

    logic [IRQ_N-1:0]    sync_q [SYNC_STAGES];
    logic [IRQ_N-1:0]    s;
    logic [IRQ_N-1:0]    s_d;
    logic [IRQ_N-1:0]    set;
    logic [IRQ_N-1:0]    clr;
    logic [IRQ_N-1:0]    pending_q;
    logic [IRQ_N-1:0]    eligible;
    logic [IRQ_ID_W-1:0] sel_id;
    logic                sel_any;
    logic                handshake;
    irq_state_t          state_q;
    irq_state_t          state_d;
    logic [IRQ_ID_W-1:0] id_q;
    logic [IRQ_ID_W-1:0] id_d;

    // Synchroniser chain per line plus one extra flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_d <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d <= s;
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign irq_valid = (state_q == OFFER);
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign handshake = irq_valid & irq_ready;
    assign clr       = handshake ? id_onehot(id_q) : '0;
    assign eligible  = pending_q & mask_in;

`ifdef IRQ_EDGE_DETECT_EN
    logic [IRQ_N-1:0] lost_q;

    assign set  = s & ~s_d;
    assign lost = lost_q;

    // Sticky overrun flags; a fresh overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_q <= '0;
        end else begin
            lost_q <= (lost_clr ? '0 : lost_q) | (set & pending_q & ~clr);
        end
    end
`else
    logic unused_level;

    assign set          = s;
    assign lost         = '0;
    assign unused_level = ^{lost_clr, s_d};
`endif

    // Pending capture: the accepted line is cleared, a new request re-sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | set;
        end
    end

    irq_prio_sel u_prio_sel (
        .eligible (eligible),
        .id       (sel_id),
        .any      (sel_any)
    );

    // Offer FSM state and latched ID registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_RST;
            id_q    <= ID_RST;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Next-state logic: latch an ID from IDLE, hold it until accepted in OFFER.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d = OFFER;
                    id_d    = sel_id;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_request_dispatcher.sv
// Self-checking bench for irq_request_dispatcher; honours IRQ_EDGE_DETECT_EN.
module tb_irq_request_dispatcher;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] mask_in;
    logic       irq_ready;
    logic       lost_clr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] lost;

    int compare_count;
    int mismatch_count;

    // Reference model state, describing the DUT after the latest rising edge.
    bit         m_known;
    bit         m_valid;
    int         m_id;
    bit [3:0]   m_pending;
    bit [3:0]   m_lost;
    bit [3:0]   m_hist [SYNC+1];

    irq_request_dispatcher #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_in   (mask_in),
        .irq_ready (irq_ready),
        .lost_clr  (lost_clr),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .lost      (lost)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the reference model across one rising edge using the current inputs.
    task automatic modelStep();
        bit [3:0] s_now;
        bit [3:0] s_old;
        bit [3:0] rise;
        bit [3:0] clear;
        bit [3:0] elig;
        int       top;
        if (rst) begin
            m_known   = 1'b1;
            m_valid   = 1'b0;
            m_id      = 0;
            m_pending = 4'b0000;
            m_lost    = 4'b0000;
            for (int k = 0; k <= SYNC; k++) m_hist[k] = 4'b0000;
            return;
        end
        // m_hist[0] is the newest sample; the line seen by capture is SYNC-1 edges old
        s_now = m_hist[SYNC-1];
        s_old = m_hist[SYNC];
`ifdef IRQ_EDGE_DETECT_EN
        rise = s_now & ~s_old;
`else
        rise = s_now;
`endif
        clear = 4'b0000;
        if (m_valid && irq_ready) clear[m_id] = 1'b1;
        elig = m_pending & mask_in;
        top = -1;
        for (int b = 3; b >= 0; b--) begin
            if (elig[b] && top < 0) top = b;
        end
`ifdef IRQ_EDGE_DETECT_EN
        if (lost_clr) m_lost = 4'b0000;
        m_lost = m_lost | (rise & m_pending & ~clear);
`endif
        if (!m_valid) begin
            if (top >= 0) begin
                m_valid = 1'b1;
                m_id    = top;
            end
        end else if (irq_ready) begin
            m_valid = 1'b0;
        end
        m_pending = (m_pending & ~clear) | rise;
        for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = irq_in;
    endtask

    // Compare at the falling edge, then drive new inputs and step the model on the rising edge.
    task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] mask,
                                 input logic ready, input logic lclr, input logic r);
        @(negedge clk);
        if (m_known) begin
            checkOutput("valid",   8'(irq_valid), 8'(m_valid));
            checkOutput("id",      8'(irq_id),    8'(m_id));
            checkOutput("pending", 8'(pending),   8'(m_pending));
            checkOutput("lost",    8'(lost),      8'(m_lost));
        end
        irq_in    = irq;
        mask_in   = mask;
        irq_ready = ready;
        lost_clr  = lclr;
        rst       = r;
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        logic [3:0] r_irq;
        logic [3:0] r_mask;
        compare_count  = 0;
        mismatch_count = 0;
        m_known        = 1'b0;
        irq_in         = 4'b0000;
        mask_in        = 4'b1111;
        irq_ready      = 1'b0;
        lost_clr       = 1'b0;
        rst            = 1'b1;

        // Reset state
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("rst_valid",   8'(irq_valid), 8'h00);
        checkOutput("rst_pending", 8'(pending),   8'h00);
        checkOutput("rst_lost",    8'(lost),      8'h00);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);

        // Single request on line 0, consumer always ready
        applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s1_valid", 8'(irq_valid), 8'h01);
        checkOutput("s1_id",    8'(irq_id),    8'h00);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s1_pending", 8'(pending), 8'h00);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Two simultaneous requests, consumer stalls for five cycles
        applyStimulus(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("s2_hold_valid", 8'(irq_valid), 8'h01);
            checkOutput("s2_hold_id",    8'(irq_id),    8'h03);
        end
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s2_bubble", 8'(irq_valid), 8'h00);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("s2_next_valid", 8'(irq_valid), 8'h01);
        checkOutput("s2_next_id",    8'(irq_id),    8'h01);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s2_pending", 8'(pending), 8'h00);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Masked line stays pending and is offered once unmasked
        applyStimulus(4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("s3_masked_valid", 8'(irq_valid), 8'h00);
        checkOutput("s3_masked_pend",  8'(pending),   8'h08);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("s3_unmask_valid", 8'(irq_valid), 8'h01);
        checkOutput("s3_unmask_id",    8'(irq_id),    8'h03);
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Reset while an offer is outstanding
        applyStimulus(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("s6_valid",   8'(irq_valid), 8'h00);
        checkOutput("s6_pending", 8'(pending),   8'h00);
        for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s6_quiet", 8'(irq_valid), 8'h00);

        // Randomised traffic against the reference model
        r_irq  = 4'b0000;
        r_mask = 4'b1111;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) r_irq = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r_mask = 4'($urandom);
            else if ($urandom_range(0, 3) == 0) r_mask = 4'b1111;
            applyStimulus(r_irq, r_mask, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
